mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Parametrised MAR/MDR memory-interface unit for the LC-3 datapath.
//  Successor to the fixed 16-bit MAR/MDR pair: adds a read/write handshake FSM, programmable SRAM wait states and a zero-wait MMIO window.
//  Sits between the datapath BUS and external SRAM/IO. Raises R to the ISDU when an access completes.
// PARAMETERS
//  DATA_W       16       data width of BUS, MDR, SRAM and IO data
//  ADDR_W       16       address width of MAR and SRAM address
//  WAIT_CYCLES  2        SRAM access length in cycles; must be >= 1
//  MMIO_BASE    'hFE00   addresses >= this value go to IO, not SRAM
// PORTS
//  Clk        in   1       system clock, rising edge
//  Reset_al   in   1       synchronous active-low reset
//  BUS        in   DATA_W  datapath bus
//  LD_MAR     in   1       load MAR from BUS[ADDR_W-1:0]
//  LD_MDR     in   1       load MDR (source selected by MIO_EN)
//  MIO_EN     in   1       1: MDR loads from memory/IO; 0: MDR loads from BUS
//  rd_req     in   1       start a read of MAR; sampled in IDLE only
//  wr_req     in   1       start a write of MDR to MAR; sampled in IDLE only
//  mem_rdata  in   DATA_W  SRAM read data
//  io_rdata   in   DATA_W  MMIO read data
//  MAR        out  ADDR_W  address register
//  MDR        out  DATA_W  data register
//  R          out  1       access-complete pulse, 1 cycle
//  busy       out  1       high in any state other than IDLE
//  err        out  1       protocol-error pulse, 1 cycle
//  mem_addr   out  ADDR_W  SRAM address = MAR
//  mem_wdata  out  DATA_W  SRAM write data = MDR
//  mem_ce_n, mem_oe_n, mem_we_n   out  1 each   SRAM strobes, active low
//  io_sel     out  1       MMIO access in progress
//  io_we      out  1       MMIO write strobe
// BEHAVIOUR
//  Reset (Reset_al=0 at a rising edge):
//   - FSM goes to IDLE; MAR=0, MDR=0, counter=0.
//   - R=0, err=0, busy=0, io_sel=0, io_we=0; all mem_*_n=1.
//   - Reset applied during an access aborts it; no R is issued.
//  FSM states: IDLE, RD_WAIT, WR_WAIT.
//  IDLE:
//   - rd_req & !wr_req -> RD_WAIT; wr_req & !rd_req -> WR_WAIT; counter cleared.
//   - rd_req & wr_req -> stay IDLE, pulse err next cycle, no access.
//  Access class is fixed when the request is accepted:
//   - MAR >= MMIO_BASE: MMIO, length 1 cycle.
//   - otherwise: SRAM, length WAIT_CYCLES.
//  RD_WAIT:
//   - SRAM strobes: ce_n=0, oe_n=0. MMIO: io_sel=1.
//   - Counter increments each cycle. R=1 combinationally when cnt==len-1.
//   - At that edge: MDR <= mem_rdata or io_rdata (when MIO_EN=1), then -> IDLE.
//  WR_WAIT:
//   - SRAM strobes: ce_n=0, we_n=0. MMIO: io_sel=1, io_we=1.
//   - R at cnt==len-1, then -> IDLE. MDR is unchanged.
//  Latency: request accepted at edge T; R high in cycle T+len; next request can be accepted at edge T+len+1.
//  LD_MAR, and LD_MDR with MIO_EN=0, act only in IDLE:
//   - In other states they are ignored and pulse err, so address/data stay stable.
//  LD_MDR with MIO_EN=1 in IDLE: no effect. MDR is loaded from memory only at read completion.
//  rd_req/wr_req while busy: ignored, no err. The controller holds them until R.
//  Counter width = $clog2(WAIT_CYCLES+1). Counter stops at len-1 and never wraps.
// STRUCTURE
//  Package mem_access_pkg:
//   - typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t
//   - default MMIO_BASE and WAIT_CYCLES constants
//  Sub-module wait_timer (clear, enable, terminal-count compare) holds the wait counter.
//  FSM, registers and strobe decode live in this module.
// TESTING
//  1. Reset_al=0 for 2 cycles -> MAR=0, MDR=0, R=0, busy=0, mem_ce_n=mem_oe_n=mem_we_n=1.
//  2. BUS=16'h3000 with LD_MAR, then rd_req, mem_rdata=16'hBEEF, MIO_EN=1, W=2 -> oe_n low 2 cycles; R in 2nd cycle; MDR=16'hBEEF next cycle.
//  3. MDR loaded with 16'h1234 via BUS (MIO_EN=0), MAR=16'h0040, wr_req -> we_n low 2 cycles, mem_wdata=16'h1234, single R pulse.
//  4. MAR=16'hFE04, rd_req, io_rdata=16'h00A5 -> io_sel 1 cycle, R in same cycle, MDR=16'h00A5, mem_ce_n stays 1.
//  5. rd_req=wr_req=1 in IDLE -> err pulse, busy stays 0. LD_MAR during RD_WAIT -> err pulse, MAR unchanged.
//  6. Reset_al=0 in cycle 1 of an SRAM read -> IDLE at next edge, strobes high, no R, MDR=0.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the MAR/MDR memory access unit.
// Strobe bundle is active-low for SRAM, active-high for MMIO.
package mem_access_pkg;
   typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} mem_state_t;

   localparam int          WAIT_CYCLES_DEF = 2;
   localparam int unsigned MMIO_BASE_DEF   = 32'hFE00;

   typedef struct packed {
      logic ce_n;
      logic oe_n;
      logic we_n;
      logic io_sel;
      logic io_we;
   } strobe_t;
endpackage

// File: rtl/wait_timer.sv
// Access-length counter: cleared on request accept, counts while busy,
// parks at the terminal value instead of wrapping.
module wait_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          en,
   input  logic [CW-1:0] last,
   output logic          tc
);
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (clr)
         cnt <= '0;
      else if (en && !tc)
         cnt <= cnt + CW'(1);
   end

   assign tc = (cnt == last);
endmodule

// File: rtl/mem_access_unit.sv
// LC-3 MAR/MDR memory interface: read/write handshake FSM with
// programmable SRAM wait states and a single-cycle MMIO window.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int          DATA_W      = 16,
   parameter int          ADDR_W      = 16,
   parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
   parameter int unsigned MMIO_BASE   = MMIO_BASE_DEF
) (
   input  logic              Clk,
   input  logic              Reset_al,
   input  logic [DATA_W-1:0] BUS,
   input  logic              LD_MAR,
   input  logic              LD_MDR,
   input  logic              MIO_EN,
   input  logic              rd_req,
   input  logic              wr_req,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] MAR,
   output logic [DATA_W-1:0] MDR,
   output logic              R,
   output logic              busy,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              io_sel,
   output logic              io_we
);
   localparam int                CW        = $clog2(WAIT_CYCLES + 1);
   localparam logic [ADDR_W-1:0] MMIO_LIM  = ADDR_W'(MMIO_BASE);
   localparam logic [CW-1:0]     SRAM_LAST = CW'(WAIT_CYCLES - 1);

   mem_state_t    state, state_nxt;
   strobe_t       stb;
   logic          idle, accept_rd, accept_wr, accept;
   logic          is_io, tc;
   logic [CW-1:0] last;

   assign idle      = (state == IDLE);
   assign accept_rd = idle && rd_req && !wr_req;
   assign accept_wr = idle && wr_req && !rd_req;
   assign accept    = accept_rd || accept_wr;
   assign last      = is_io ? '0 : SRAM_LAST;

   // Reset shares the clear path so the counter restarts with the FSM.
   wait_timer #(.CW(CW)) u_timer (
      .clk  (Clk),
      .clr  (!Reset_al || accept),
      .en   (!idle),
      .last (last),
      .tc   (tc)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_al)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge Clk) begin
      if (!Reset_al) begin
         MAR   <= '0;
         MDR   <= '0;
         is_io <= 1'b0;
         err   <= 1'b0;
      end else begin
         // Register writes while busy would corrupt an in-flight access.
         err <= (idle && rd_req && wr_req) ||
                (!idle && (LD_MAR || (LD_MDR && !MIO_EN)));
         if (idle && LD_MAR)
            MAR <= BUS[ADDR_W-1:0];
         if (idle && LD_MDR && !MIO_EN)
            MDR <= BUS;
         else if (state == RD_WAIT && tc && MIO_EN)
            MDR <= is_io ? io_rdata : mem_rdata;
         if (accept)
            is_io <= (MAR >= MMIO_LIM);
      end
   end

   always_comb begin
      state_nxt  = state;
      stb.ce_n   = 1'b1;
      stb.oe_n   = 1'b1;
      stb.we_n   = 1'b1;
      stb.io_sel = 1'b0;
      stb.io_we  = 1'b0;
      case (state)
         IDLE: begin
            if (accept_rd)
               state_nxt = RD_WAIT;
            else if (accept_wr)
               state_nxt = WR_WAIT;
         end
         RD_WAIT: begin
            if (is_io) begin
               stb.io_sel = 1'b1;
            end else begin
               stb.ce_n = 1'b0;
               stb.oe_n = 1'b0;
            end
            if (tc)
               state_nxt = IDLE;
         end
         WR_WAIT: begin
            if (is_io) begin
               stb.io_sel = 1'b1;
               stb.io_we  = 1'b1;
            end else begin
               stb.ce_n = 1'b0;
               stb.we_n = 1'b0;
            end
            if (tc)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign R         = !idle && tc;
   assign busy      = !idle;
   assign mem_addr  = MAR;
   assign mem_wdata = MDR;
   assign mem_ce_n  = stb.ce_n;
   assign mem_oe_n  = stb.oe_n;
   assign mem_we_n  = stb.we_n;
   assign io_sel    = stb.io_sel;
   assign io_we     = stb.io_we;
endmodule
